// File: rtl/store_buffer.sv
// Word-store write buffer: FIFO of committed stores draining to the data memory,
// with youngest-match load forwarding and partial-overlap conflict detection.
module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     nop,
    input  logic                     st_valid,
    input  logic [AW-1:0]            st_addr,
    input  logic [DW-1:0]            st_data,
    output logic                     st_ready,
    input  logic                     ld_valid,
    input  logic [AW-1:0]            ld_addr,
    output logic                     ld_hit,
    output logic [DW-1:0]            ld_data,
    output logic                     ld_conflict,
    input  logic                     mem_grant,
    output logic                     mem_write,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_wdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    logic             push;
    logic             pop;
    logic [PW-1:0]    idx_c;
    logic [AW-1:0]    diff_fwd_c;
    logic [AW-1:0]    diff_bwd_c;

    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign mem_write = !empty && mem_grant && !rst;
    assign st_ready  = !rst && ((count_q < CW'(DEPTH)) || mem_write);
    assign mem_addr  = addr_q[head_q];
    assign mem_wdata = data_q[head_q];
    assign push      = st_valid && !nop && st_ready;
    assign pop       = mem_write;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; a full-and-draining push reuses the slot being freed, so set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            count_q <= count_d;
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PW'(1);
            end
            if (push) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PW'(1);
            end
        end
    end

    // Payload storage carries no reset; validity lives in valid_q.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            addr_q[tail_q] <= st_addr;
            data_q[tail_q] <= st_data;
        end
    end

    // Walk oldest to youngest so the youngest exact match wins the forwarded data.
    always_comb begin
        ld_hit      = 1'b0;
        ld_conflict = 1'b0;
        ld_data     = '0;
        idx_c       = '0;
        diff_fwd_c  = '0;
        diff_bwd_c  = '0;
        if (ld_valid && !nop && !rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                idx_c      = head_q + PW'(i);
                diff_fwd_c = ld_addr - addr_q[idx_c];
                diff_bwd_c = addr_q[idx_c] - ld_addr;
                if (valid_q[idx_c]) begin
                    if (diff_fwd_c == '0) begin
                        ld_hit  = 1'b1;
                        ld_data = data_q[idx_c];
                    end else if ((diff_fwd_c <= AW'(3)) || (diff_bwd_c <= AW'(3))) begin
                        ld_conflict = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: drain order checked by a scoreboard queue,
// forwarding/conflict/reset behaviour checked with immediate assertions.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        nop;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        ld_conflict;
    logic        mem_grant;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        empty;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] sb [$];

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst), .nop(nop),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
        .ld_conflict(ld_conflict), .mem_grant(mem_grant), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .empty(empty), .count(count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_st(input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        #1;
        chk("push_ready", 32'(st_ready), 32'd1);
        sb.push_back({a, d});
        cyc();
        st_valid = 1'b0;
    endtask

    task automatic drain_all(input string tag);
        mem_grant = 1'b1;
        for (int i = 0; i < 8 && !empty; i++) cyc();
        mem_grant = 1'b0;
        chk(tag, 32'(empty), 32'd1);
    endtask

    // Every memory write is compared against the oldest expected store.
    always @(negedge clk) begin
        if (mem_write) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_write", 32'(mem_write), 32'd0);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                chk("sb_addr", mem_addr, e[63:32]);
                chk("sb_data", mem_wdata, e[31:0]);
            end
        end
    end

    initial begin
        rst = 1'b1; nop = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0;
        ld_valid = 1'b0; ld_addr = '0; mem_grant = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_st_ready", 32'(st_ready), 32'd0);
        rst = 1'b0; mem_grant = 1'b0;
        cyc();
        chk("post_rst_count", 32'(count), 32'd0);
        chk("post_rst_empty", 32'(empty), 32'd1);
        chk("post_rst_ready", 32'(st_ready), 32'd1);
        chk("post_rst_ld_data", ld_data, 32'd0);

        // Three pushes held back, then drained in order.
        push_st(32'h10, 32'hAAAA0001);
        push_st(32'h20, 32'hBBBB0002);
        push_st(32'h30, 32'hCCCC0003);
        chk("three_count", 32'(count), 32'd3);
        chk("three_no_write", 32'(mem_write), 32'd0);
        chk("three_head", mem_addr, 32'h10);
        mem_grant = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("drain_write", 32'(mem_write), 32'd1);
            chk("drain_addr", mem_addr, 32'h10 + 32'(i) * 32'h10);
            cyc();
        end
        mem_grant = 1'b0;
        #1;
        chk("drained_empty", 32'(empty), 32'd1);
        chk("drained_count", 32'(count), 32'd0);

        // Full buffer: reject, then accept while draining.
        for (int i = 0; i < 4; i++) push_st(32'h100 + 32'(i) * 4, 32'h5000_0000 + 32'(i));
        chk("full_count", 32'(count), 32'd4);
        chk("full_not_ready", 32'(st_ready), 32'd0);
        st_valid = 1'b1; st_addr = 32'h200; st_data = 32'hDEAD0200;
        cyc();
        chk("full_reject_count", 32'(count), 32'd4);
        mem_grant = 1'b1;
        #1;
        chk("full_drain_ready", 32'(st_ready), 32'd1);
        chk("full_drain_head", mem_addr, 32'h100);
        sb.push_back({32'h200, 32'hDEAD0200});
        cyc();
        st_valid = 1'b0; mem_grant = 1'b0;
        #1;
        chk("full_swap_count", 32'(count), 32'd4);
        chk("full_swap_head", mem_addr, 32'h104);
        drain_all("full_drain_empty");

        // Youngest match forwarding.
        push_st(32'h40, 32'h11111111);
        push_st(32'h40, 32'h22222222);
        ld_valid = 1'b1; ld_addr = 32'h40;
        #1;
        chk("fwd_hit", 32'(ld_hit), 32'd1);
        chk("fwd_data", ld_data, 32'h22222222);
        chk("fwd_no_conflict", 32'(ld_conflict), 32'd0);
        nop = 1'b1;
        #1;
        chk("fwd_nop_hit", 32'(ld_hit), 32'd0);
        chk("fwd_nop_data", ld_data, 32'd0);
        nop = 1'b0; ld_addr = 32'h44;
        #1;
        chk("fwd_miss_hit", 32'(ld_hit), 32'd0);
        chk("fwd_miss_conflict", 32'(ld_conflict), 32'd0);
        ld_valid = 1'b0;
        drain_all("fwd_drain_empty");

        // Partial overlap, including the head being drained this cycle.
        push_st(32'h40, 32'h33333333);
        ld_valid = 1'b1; ld_addr = 32'h42;
        #1;
        chk("ovl_conflict", 32'(ld_conflict), 32'd1);
        chk("ovl_hit", 32'(ld_hit), 32'd0);
        mem_grant = 1'b1;
        #1;
        chk("ovl_draining_conflict", 32'(ld_conflict), 32'd1);
        cyc();
        mem_grant = 1'b0;
        #1;
        chk("ovl_cleared", 32'(ld_conflict), 32'd0);
        ld_valid = 1'b0;
        push_st(32'hFFFFFFFE, 32'h44444444);
        ld_valid = 1'b1; ld_addr = 32'h0;
        #1;
        chk("wrap_conflict", 32'(ld_conflict), 32'd1);
        chk("wrap_hit", 32'(ld_hit), 32'd0);
        ld_addr = 32'hFFFFFFFB;
        #1;
        chk("minus3_conflict", 32'(ld_conflict), 32'd1);
        ld_addr = 32'hFFFFFFFA;
        #1;
        chk("minus4_conflict", 32'(ld_conflict), 32'd0);
        ld_addr = 32'h00000002;
        #1;
        chk("plus4_conflict", 32'(ld_conflict), 32'd0);
        ld_valid = 1'b0;
        drain_all("wrap_drain_empty");

        // Reset with entries held discards them without writing memory.
        push_st(32'h50, 32'h55555555);
        push_st(32'h54, 32'h66666666);
        rst = 1'b1; mem_grant = 1'b1; ld_valid = 1'b1; ld_addr = 32'h50;
        sb.delete();
        #1;
        chk("rst_held_write", 32'(mem_write), 32'd0);
        chk("rst_held_hit", 32'(ld_hit), 32'd0);
        cyc();
        rst = 1'b0; mem_grant = 1'b0; ld_valid = 1'b0;
        #1;
        chk("rst_held_count", 32'(count), 32'd0);
        chk("rst_held_empty", 32'(empty), 32'd1);

        // Store in a bubble is not accepted.
        nop = 1'b1; st_valid = 1'b1; st_addr = 32'h60; st_data = 32'h77777777;
        cyc();
        nop = 1'b0; st_valid = 1'b0;
        #1;
        chk("nop_count", 32'(count), 32'd0);
        chk("nop_empty", 32'(empty), 32'd1);
        chk("sb_leftover", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
